// File: rtl/burst_accum_pkg.sv
// Shared definitions for the burst accumulator.
// Holds the accumulator FSM state encoding and the constant functions that
// give the signed saturation limits for a given accumulator width.
package burst_accum_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    // Largest value representable in a signed field of the given width.
    function automatic longint acc_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in a signed field of the given width.
    function automatic longint acc_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/burst_accum_valid_delay.sv
// valid_delay: fixed-length shift register that carries per-beat control
// bits alongside the upstream multiplier pipe so they line up with the product.
// Ports:
//   clk  - clock, all logic on posedge
//   rst  - synchronous active-high reset, clears every stage
//   i_d  - WIDTH control bits entering with the operands
//   o_q  - the same bits, LATENCY cycles later
// LATENCY must be at least 1.
module valid_delay #(
    parameter int LATENCY = 5,
    parameter int WIDTH   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_pipe [LATENCY];

    // Shift the control bits one stage per cycle; reset empties the line so
    // beats launched before reset never surface afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_q = r_pipe[LATENCY-1];

endmodule

// File: rtl/burst_accum.sv
// burst_accum: sums the signed products of a burst arriving from a fixed
// latency multiplier and presents one registered result per burst.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   in_valid   - beat launched into the multiplier this cycle
//   in_last    - launched beat is the final one of its burst
//   prod       - signed multiplier output, LATENCY cycles after launch
//   out_data   - saturated signed burst sum
//   out_count  - beats in the burst (saturates at all-ones)
//   out_sat    - burst sum saturated at some point in the burst
//   out_valid  - result held for downstream
//   out_ready  - downstream takes the result
//   drop_err   - sticky: a result arrived while the output was still full
module burst_accum
    import burst_accum_pkg::*;
#(
    parameter int WIDTH_P   = 16,
    parameter int WIDTH_ACC = 24,
    parameter int LATENCY   = 5,
    parameter int WIDTH_CNT = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic                        in_last,
    input  logic signed [WIDTH_P-1:0]   prod,
    output logic signed [WIDTH_ACC-1:0] out_data,
    output logic [WIDTH_CNT-1:0]        out_count,
    output logic                        out_sat,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        drop_err
);

    localparam logic [WIDTH_ACC-1:0] ACC_MAX = WIDTH_ACC'(acc_max(WIDTH_ACC));
    localparam logic [WIDTH_ACC-1:0] ACC_MIN = WIDTH_ACC'(acc_min(WIDTH_ACC));
    localparam logic [WIDTH_CNT-1:0] CNT_MAX = '1;
    localparam logic [WIDTH_CNT-1:0] CNT_ONE = WIDTH_CNT'(1);

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [WIDTH_ACC-1:0]   r_acc;
    logic [WIDTH_ACC-1:0]   w_acc_nxt;
    logic [WIDTH_CNT-1:0]   r_cnt;
    logic [WIDTH_CNT-1:0]   w_cnt_nxt;
    logic                   r_sat;
    logic                   w_sat_nxt;

    logic [1:0]             w_aligned;
    logic                   w_a_valid;
    logic                   w_a_last;

    logic [WIDTH_ACC-1:0]   w_prod_ext;
    logic [WIDTH_ACC:0]     w_sum_wide;
    logic                   w_ovf;
    logic [WIDTH_ACC-1:0]   w_sum_sat;
    logic [WIDTH_CNT-1:0]   w_cnt_inc;

    logic                   w_emit;
    logic [WIDTH_ACC-1:0]   w_res_data;
    logic [WIDTH_CNT-1:0]   w_res_cnt;
    logic                   w_res_sat;

    logic [WIDTH_ACC-1:0]   r_out_data;
    logic [WIDTH_CNT-1:0]   r_out_count;
    logic                   r_out_sat;
    logic                   r_out_valid;
    logic                   r_drop_err;

    // in_last only means something on a valid beat, so qualify it before delaying.
    valid_delay #(
        .LATENCY (LATENCY),
        .WIDTH   (2)
    ) u_valid_delay (
        .clk (clk),
        .rst (rst),
        .i_d ({in_last & in_valid, in_valid}),
        .o_q (w_aligned)
    );

    assign w_a_valid = w_aligned[0];
    assign w_a_last  = w_aligned[1];

    // One guard bit catches overflow: the top two sum bits differ exactly when
    // the true sum left the signed range, and the guard bit gives the direction.
    assign w_prod_ext = {{(WIDTH_ACC-WIDTH_P){prod[WIDTH_P-1]}}, prod};
    assign w_sum_wide = {r_acc[WIDTH_ACC-1], r_acc} + {w_prod_ext[WIDTH_ACC-1], w_prod_ext};
    assign w_ovf      = w_sum_wide[WIDTH_ACC] ^ w_sum_wide[WIDTH_ACC-1];
    assign w_sum_sat  = w_ovf ? (w_sum_wide[WIDTH_ACC] ? ACC_MIN : ACC_MAX)
                              : w_sum_wide[WIDTH_ACC-1:0];
    assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_ONE);

    // Next-state and result generation for the aligned beat.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_sat_nxt   = r_sat;
        w_emit      = 1'b0;
        w_res_data  = '0;
        w_res_cnt   = '0;
        w_res_sat   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_a_valid && w_a_last) begin
                    // Single-beat burst never enters ACCUM.
                    w_emit     = 1'b1;
                    w_res_data = w_prod_ext;
                    w_res_cnt  = CNT_ONE;
                    w_res_sat  = 1'b0;
                end else if (w_a_valid) begin
                    w_acc_nxt   = w_prod_ext;
                    w_cnt_nxt   = CNT_ONE;
                    w_sat_nxt   = 1'b0;
                    w_state_nxt = ST_ACCUM;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (w_a_valid) begin
                    w_acc_nxt = w_sum_sat;
                    w_cnt_nxt = w_cnt_inc;
                    w_sat_nxt = r_sat | w_ovf;
                    if (w_a_last) begin
                        w_emit      = 1'b1;
                        w_res_data  = w_sum_sat;
                        w_res_cnt   = w_cnt_inc;
                        w_res_sat   = r_sat | w_ovf;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_ACCUM;
                    end
                end else begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Accumulator state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sat   <= w_sat_nxt;
        end
    end

    // Output holding register: a new result may replace one being accepted in
    // the same cycle; one that finds the register still full is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_sat   <= 1'b0;
            r_out_valid <= 1'b0;
            r_drop_err  <= 1'b0;
        end else if (w_emit) begin
            if (!r_out_valid || out_ready) begin
                r_out_data  <= w_res_data;
                r_out_count <= w_res_cnt;
                r_out_sat   <= w_res_sat;
                r_out_valid <= 1'b1;
            end else begin
                r_drop_err  <= 1'b1;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign out_data  = r_out_data;
    assign out_count = r_out_count;
    assign out_sat   = r_out_sat;
    assign out_valid = r_out_valid;
    assign drop_err  = r_drop_err;

endmodule

// File: tb/tb_burst_accum.sv
// Self-checking bench for burst_accum: directed table, hand-written corner
// sequences and a randomized run, all scored against a burst-level model.
module tb_burst_accum;

    localparam int WP   = 16;
    localparam int WA   = 24;
    localparam int LAT  = 5;
    localparam int WC   = 8;
    localparam int AMAX = 8388607;
    localparam int AMIN = -8388608;
    localparam int CMAX = 255;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_last;
    logic signed [WP-1:0] prod;
    logic signed [WA-1:0] out_data;
    logic [WC-1:0]        out_count;
    logic                 out_sat;
    logic                 out_valid;
    logic                 out_ready;
    logic                 drop_err;

    burst_accum #(.WIDTH_P(WP), .WIDTH_ACC(WA), .LATENCY(LAT), .WIDTH_CNT(WC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .prod      (prod),
        .out_data  (out_data),
        .out_count (out_count),
        .out_sat   (out_sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int launch_p [0:8191];

    // Burst-level reference: sums computed at launch, results scheduled by due cycle.
    typedef struct {
        int due;
        int data;
        int cnt;
        bit sat;
    } res_t;
    res_t pend[$];
    bit   m_busy = 1'b0;
    int   m_sum  = 0;
    int   m_cnt  = 0;
    bit   m_sat  = 1'b0;
    bit   e_valid = 1'b0;
    int   e_data  = 0;
    int   e_cnt   = 0;
    bit   e_sat   = 1'b0;
    bit   e_drop  = 1'b0;

    typedef struct {
        int n;
        int p [4];
        int exp_data;
        int exp_cnt;
        int exp_sat;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_edge(input logic v, input logic l, input int p, input logic rdy, input logic r);
        res_t nr;
        if (r) begin
            pend.delete();
            m_busy  = 1'b0;
            e_valid = 1'b0;
            e_data  = 0;
            e_cnt   = 0;
            e_sat   = 1'b0;
            e_drop  = 1'b0;
        end else begin
            if (pend.size() > 0 && pend[0].due == cyc) begin
                nr = pend.pop_front();
                if (!e_valid || rdy) begin
                    e_valid = 1'b1;
                    e_data  = nr.data;
                    e_cnt   = nr.cnt;
                    e_sat   = nr.sat;
                end else begin
                    e_drop = 1'b1;
                end
            end else if (rdy) begin
                e_valid = 1'b0;
            end
            if (v) begin
                if (!m_busy) begin
                    m_sum = p;
                    m_cnt = 1;
                    m_sat = 1'b0;
                end else begin
                    m_sum = m_sum + p;
                    if (m_sum > AMAX) begin m_sum = AMAX; m_sat = 1'b1; end
                    if (m_sum < AMIN) begin m_sum = AMIN; m_sat = 1'b1; end
                    m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
                end
                m_busy = 1'b1;
                if (l) begin
                    nr.due  = cyc + LAT;
                    nr.data = m_sum;
                    nr.cnt  = m_cnt;
                    nr.sat  = m_sat;
                    pend.push_back(nr);
                    m_busy = 1'b0;
                end
            end
        end
    endtask

    task automatic compare();
        chk("out_valid", longint'(out_valid), longint'(e_valid));
        if (e_valid) begin
            chk("out_data", longint'(out_data), longint'(e_data));
            chk("out_count", longint'(out_count), longint'(e_cnt));
            chk("out_sat", longint'(out_sat), longint'(e_sat));
        end
        chk("drop_err", longint'(drop_err), longint'(e_drop));
    endtask

    // One clock: launch a beat (product reappears LAT cycles later), then score.
    task automatic step(input logic v, input logic l, input int p, input logic rdy, input logic r);
        int pv;
        pv = v ? p : (int'($urandom_range(65535)) - 32768);
        launch_p[cyc] = pv;
        rst       = r;
        in_valid  = v;
        in_last   = l;
        out_ready = rdy;
        if (cyc >= LAT) prod = WP'(launch_p[cyc-LAT]);
        else prod = WP'(pv);
        @(posedge clk);
        #1;
        cyc++;
        model_edge(v, l, p, rdy, r);
        compare();
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic wait_result(input string nm, input int ed, input int ec, input int es,
                               input int t_last, input logic rdy);
        int k;
        k = 0;
        while (out_valid !== 1'b1 && k < 40) begin
            step(1'b0, 1'b0, 0, rdy, 1'b0);
            k++;
        end
        if (out_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: out_valid never rose within 40 cycles", nm);
        end else begin
            chk({nm, "_data"}, longint'(out_data), longint'(ed));
            chk({nm, "_count"}, longint'(out_count), longint'(ec));
            chk({nm, "_sat"}, longint'(out_sat), longint'(es));
            chk({nm, "_latency"}, longint'(cyc - t_last), longint'(LAT + 1));
        end
    endtask

    initial begin
        int t;
        int p;
        logic v;
        logic l;

        tbl[0] = '{n: 4, p: '{3, -5, 10, 7},                 exp_data: 15,     exp_cnt: 4, exp_sat: 0};
        tbl[1] = '{n: 1, p: '{-32768, 0, 0, 0},              exp_data: -32768, exp_cnt: 1, exp_sat: 0};
        tbl[2] = '{n: 1, p: '{32767, 0, 0, 0},               exp_data: 32767,  exp_cnt: 1, exp_sat: 0};
        tbl[3] = '{n: 2, p: '{1, 1, 0, 0},                   exp_data: 2,      exp_cnt: 2, exp_sat: 0};
        tbl[4] = '{n: 3, p: '{-32768, -32768, -32768, 0},    exp_data: -98304, exp_cnt: 3, exp_sat: 0};
        tbl[5] = '{n: 4, p: '{100, -100, 5, -6},             exp_data: -1,     exp_cnt: 4, exp_sat: 0};

        // Reset state.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b1);
        chk("reset_valid", longint'(out_valid), 0);
        chk("reset_data", longint'(out_data), 0);
        chk("reset_count", longint'(out_count), 0);
        chk("reset_drop", longint'(drop_err), 0);

        // Table of back-to-back bursts.
        for (int i = 0; i < 6; i++) begin
            flush(3);
            t = 0;
            for (int b = 0; b < tbl[i].n; b++) begin
                if (b == tbl[i].n - 1) t = cyc;
                step(1'b1, b == tbl[i].n - 1, tbl[i].p[b], 1'b1, 1'b0);
            end
            wait_result($sformatf("tbl%0d", i), tbl[i].exp_data, tbl[i].exp_cnt, tbl[i].exp_sat, t, 1'b1);
        end

        // Long burst: sum and count both saturate.
        flush(3);
        t = 0;
        for (int i = 0; i < 300; i++) begin
            if (i == 299) t = cyc;
            step(1'b1, i == 299, 32767, 1'b1, 1'b0);
        end
        wait_result("sat300", AMAX, CMAX, 1, t, 1'b1);

        // Gaps inside a burst.
        flush(3);
        step(1'b1, 1'b0, 2, 1'b1, 1'b0);
        step(1'b0, 1'b0, 0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 4, 1'b1, 1'b0);
        t = cyc;
        step(1'b1, 1'b1, 6, 1'b1, 1'b0);
        wait_result("gaps", 12, 3, 0, t, 1'b1);

        // Held result, dropped result, then replacement on acceptance.
        flush(3);
        step(1'b1, 1'b0, 5, 1'b0, 1'b0);
        t = cyc;
        step(1'b1, 1'b1, 6, 1'b0, 1'b0);
        wait_result("held1", 11, 2, 0, t, 1'b0);
        step(1'b1, 1'b0, 1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 2, 1'b0, 1'b0);
        for (int i = 0; i < LAT + 2; i++) step(1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk("hold_data", longint'(out_data), 11);
        chk("hold_valid", longint'(out_valid), 1);
        chk("drop_set", longint'(drop_err), 1);
        step(1'b1, 1'b0, 7, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8, 1'b0, 1'b0);
        for (int i = 0; i < LAT - 1; i++) step(1'b0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b1, 1'b0);
        chk("swap_valid", longint'(out_valid), 1);
        chk("swap_data", longint'(out_data), 15);
        chk("swap_count", longint'(out_count), 2);
        chk("drop_sticky", longint'(drop_err), 1);
        step(1'b0, 1'b0, 0, 1'b1, 1'b0);
        chk("swap_clear", longint'(out_valid), 0);

        // Reset mid-burst abandons it and clears drop_err.
        flush(3);
        step(1'b1, 1'b0, 9, 1'b1, 1'b0);
        step(1'b1, 1'b0, 9, 1'b1, 1'b0);
        step(1'b0, 1'b0, 0, 1'b1, 1'b1);
        chk("rst_drop_clear", longint'(drop_err), 0);
        for (int i = 0; i < LAT + 3; i++) begin
            step(1'b0, 1'b0, 0, 1'b1, 1'b0);
            chk("rst_no_valid", longint'(out_valid), 0);
        end
        step(1'b1, 1'b0, 1, 1'b1, 1'b0);
        t = cyc;
        step(1'b1, 1'b1, 1, 1'b1, 1'b0);
        wait_result("post_rst", 2, 2, 0, t, 1'b1);

        // Randomized traffic scored by the model every cycle.
        for (int i = 0; i < 2000; i++) begin
            v = ($urandom_range(2) != 0);
            l = v && ($urandom_range(4) == 0);
            case ($urandom_range(3))
                0: p = 32767;
                1: p = -32768;
                default: p = int'($urandom_range(65535)) - 32768;
            endcase
            step(v, l, p, $urandom_range(3) != 0, $urandom_range(499) == 0);
        end
        flush(LAT + 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/burst_accum.md
BURST_ACCUM -- requirements
Module: burst_accum

Interface
REQ-001 SHALL provide parameter WIDTH_P, default 16, meaning signed product width delivered by the upstream multiplier.
REQ-002 SHALL provide parameter WIDTH_ACC, default 24, meaning signed accumulator and result width (WIDTH_ACC > WIDTH_P).
REQ-003 SHALL provide parameter LATENCY, default 5, meaning cycles from operand launch into the multiplier to the product appearing on dout_p.
REQ-004 SHALL provide parameter WIDTH_CNT, default 8, meaning beat-counter width; maximum burst length is 2**WIDTH_CNT-1.
REQ-005 clk  input  1  single clock, all logic on posedge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 in_valid  input  1  beat valid, asserted in the same cycle the operands are launched into the multiplier.
REQ-008 in_last  input  1  final beat of the burst, qualified by in_valid, same launch cycle.
REQ-009 prod  input  WIDTH_P  signed product from the multiplier dout_p, LATENCY cycles after launch.
REQ-010 out_data  output  WIDTH_ACC  signed burst sum.
REQ-011 out_count  output  WIDTH_CNT  number of beats in the burst.
REQ-012 out_sat  output  1  high when the burst sum saturated.
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  downstream accepts the result.
REQ-015 drop_err  output  1  sticky flag: a result was lost because the output register was full.

Function
REQ-016 SHALL delay in_valid and in_last by exactly LATENCY cycles through a shift register, so that the aligned beat (a_valid, a_last) coincides with the matching prod.
REQ-017 SHALL run an FSM with the states IDLE and ACCUM.
REQ-018 IDLE, a_valid && !a_last: acc = sext(prod), cnt = 1, go to ACCUM.
REQ-019 IDLE, a_valid && a_last: single-beat burst; the result is sext(prod) with count 1; stay in IDLE.
REQ-020 ACCUM, a_valid: acc = sat(acc + sext(prod)), cnt = cnt + 1; when a_last, emit the result and go to IDLE.
REQ-021 Cycles with a_valid low SHALL leave acc, cnt and the state unchanged (gaps within a burst are allowed).
REQ-022 Addition SHALL saturate to the signed WIDTH_ACC range; the sat flag latches for the rest of the burst and clears at burst start.
REQ-023 cnt SHALL saturate at 2**WIDTH_CNT-1 and never wrap.
REQ-024 The result SHALL be registered: out_valid rises the cycle after the aligned last beat; total latency from the in_last launch to out_valid is LATENCY+1 cycles.
REQ-025 out_data, out_count and out_sat SHALL hold stable while out_valid && !out_ready.
REQ-026 out_valid SHALL clear the cycle after out_valid && out_ready, unless a new result is emitted in that same cycle, in which case the new result loads with no bubble.
REQ-027 A result emitted while out_valid && !out_ready SHALL be discarded, the held result kept, and drop_err set (no backpressure is possible into the multiplier pipe).
REQ-028 In-flight beats SHALL never stall; beat acceptance is independent of out_ready.

Reset
REQ-029 While rst is high: state = IDLE, delay line cleared, acc = 0, cnt = 0, out_valid = 0, out_data = 0, out_count = 0, out_sat = 0, drop_err = 0.
REQ-030 Asserting rst mid-burst SHALL abandon the burst; products for beats launched before reset and arriving after it SHALL be ignored, because their delayed valids were cleared.
REQ-031 drop_err SHALL clear only on rst.

Structure
REQ-032 A shared package SHALL hold the FSM state enum and the saturation min/max constant functions of WIDTH_ACC.
REQ-033 The valid/last delay line SHALL be one sub-module, valid_delay, parameterised by LATENCY and width.
REQ-034 Target size: about 150-250 lines of RTL; no DSP inference in this block.

Verification
REQ-035 Burst of 4 with products 3, -5, 10, 7 launched back-to-back -> out_data 15, out_count 4, out_sat 0, out_valid high at launch-of-last + 6.
REQ-036 Single beat, in_valid=in_last=1, prod -32768 -> out_data -32768, out_count 1, no FSM entry to ACCUM.
REQ-037 300 beats of product 32767 with WIDTH_ACC 24 -> out_data 8388607, out_sat 1, out_count 255.
REQ-038 Burst 1 completes with out_ready held low, then burst 2 completes -> burst 1 value held, drop_err 1; out_ready high with a simultaneous new emission -> new result loads, out_valid stays high.
REQ-039 Beats with gaps (in_valid 1,0,0,1,1 with last on the final beat), products 2, 4, 6 -> out_data 12, out_count 3.
REQ-040 rst for 1 cycle after 2 of 4 beats launched -> no out_valid for that burst; the next 2-beat burst with products 1, 1 -> out_data 2.
